// File: rtl/poly_sched.sv
// poly_sched: round-robin two-requester scheduler for a shared-multiplier Horner evaluator of y = x^3 + x^2 + x
module poly_sched #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_data,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_data,
   output logic             req1_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_id,
   input  logic             out_ready,
   output logic             busy
);
   typedef enum logic [1:0] {IDLE, MUL1, MUL2, DONE} state_t;
   state_t state_q, state_d;
   logic [WIDTH-1:0] x_q, x_d, t_q, t_d, y_q, y_d, prod;
   logic id_q, id_d, last_q, last_d, out_valid_q, out_valid_d, busy_q, busy_d, gnt1, hs;
   always_comb begin
      gnt1 = req1_valid & (~req0_valid | ~last_q);
      req0_ready = (state_q == IDLE) & ~rst & req0_valid & ~gnt1;
      req1_ready = (state_q == IDLE) & ~rst & gnt1;
      hs = req0_ready | req1_ready;
      prod = x_q * ((state_q == MUL1) ? x_q + WIDTH'(1) : t_q + WIDTH'(1));
      x_d = req1_ready ? req1_data : req0_ready ? req0_data : x_q;
      id_d = hs ? req1_ready : id_q;
      last_d = hs ? req1_ready : last_q;
      t_d = (state_q == MUL1) ? prod : t_q;
      y_d = (state_q == MUL2) ? prod : y_q;
      state_d = (state_q == IDLE) ? (hs ? MUL1 : IDLE) :
                (state_q == MUL1) ? MUL2 :
                (state_q == MUL2) ? DONE :
                (out_ready ? IDLE : DONE);
      out_valid_d = state_d == DONE;
      busy_d = state_d != IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         x_q         <= '0;
         t_q         <= '0;
         y_q         <= '0;
         id_q        <= 1'b0;
         last_q      <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         t_q         <= t_d;
         y_q         <= y_d;
         id_q        <= id_d;
         last_q      <= last_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end
   assign out_valid = out_valid_q;
   assign out_data  = y_q;
   assign out_id    = id_q;
   assign busy      = busy_q;
endmodule

// File: tb/tb_poly_sched.sv
// tb_poly_sched: directed self-checking bench for poly_sched
module tb_poly_sched;
   logic clk = 0, rst = 1;
   logic req0_valid = 0, req1_valid = 0, out_ready = 1;
   logic [15:0] req0_data = 0, req1_data = 0;
   logic req0_ready, req1_ready, out_valid, out_id, busy;
   logic [15:0] out_data;
   int n_chk = 0, n_fail = 0, cyc = 0;
   poly_sched #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
      .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
      .out_ready(out_ready), .busy(busy)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic wait_rdy(input logic which, output logic ok);
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         if ((which ? req1_ready : req0_ready) === 1'b1) begin
            ok = 1;
            break;
         end
         step();
      end
      check("ready_timeout", {31'b0, ok}, 1);
   endtask
   task automatic single(input logic which, input logic [15:0] x, input logic [15:0] exp);
      logic ok;
      out_ready = 1;
      if (which) begin req1_valid = 1; req1_data = x; end
      else begin req0_valid = 1; req0_data = x; end
      #1;
      wait_rdy(which, ok);
      check("one_ready", {31'b0, req0_ready & req1_ready}, 0);
      step();
      req0_valid = 0;
      req1_valid = 0;
      check("mul1_busy", {31'b0, busy}, 1);
      check("mul1_nov", {31'b0, out_valid}, 0);
      step();
      check("mul2_nov", {31'b0, out_valid}, 0);
      step();
      check("done_valid", {31'b0, out_valid}, 1);
      check("done_data", {16'b0, out_data}, {16'b0, exp});
      check("done_id", {31'b0, out_id}, {31'b0, which});
      step();
      check("idle_nov", {31'b0, out_valid}, 0);
      check("idle_busy", {31'b0, busy}, 0);
   endtask
   task automatic do_reset();
      rst = 1;
      step();
      step();
      rst = 0;
   endtask
   initial begin
      logic ok;
      int last_cyc;
      logic [15:0] xs [3];
      logic [15:0] ys [3];
      xs = '{16'd2, 16'd3, 16'd4};
      ys = '{16'd14, 16'd39, 16'd84};
      #1;
      req0_valid = 1;
      req1_valid = 1;
      step();
      check("rst_rdy0", {31'b0, req0_ready}, 0);
      check("rst_rdy1", {31'b0, req1_ready}, 0);
      check("rst_ov", {31'b0, out_valid}, 0);
      check("rst_busy", {31'b0, busy}, 0);
      check("rst_data", {16'b0, out_data}, 0);
      check("rst_id", {31'b0, out_id}, 0);
      req0_valid = 0;
      req1_valid = 0;
      rst = 0;
      step();
      check("idle_rdy0", {31'b0, req0_ready}, 0);
      single(0, 16'd2, 16'd14);
      single(0, 16'd10, 16'h0456);
      single(0, 16'hFFFF, 16'hFFFF);
      single(1, 16'h0100, 16'h0100);
      single(0, 16'h0000, 16'h0000);
      do_reset();
      req0_valid = 1; req0_data = 16'd3;
      req1_valid = 1; req1_data = 16'd5;
      out_ready = 1;
      #1;
      for (int k = 0; k < 4; k++) begin
         wait_rdy(k[0], ok);
         check("cont_r0", {31'b0, req0_ready}, {31'b0, ~k[0]});
         check("cont_r1", {31'b0, req1_ready}, {31'b0, k[0]});
         for (int j = 0; j < 3; j++) begin
            step();
            check("cont_excl", {31'b0, req0_ready & req1_ready}, 0);
         end
         check("cont_ov", {31'b0, out_valid}, 1);
         check("cont_data", {16'b0, out_data}, k[0] ? 32'd155 : 32'd39);
         check("cont_id", {31'b0, out_id}, {31'b0, k[0]});
         step();
      end
      req0_valid = 0;
      req1_valid = 0;
      step();
      out_ready = 0;
      req0_valid = 1; req0_data = 16'd2;
      #1;
      wait_rdy(0, ok);
      step();
      req0_valid = 0;
      step();
      step();
      req1_valid = 1; req1_data = 16'd9;
      #1;
      for (int i = 0; i < 5; i++) begin
         check("bp_ov", {31'b0, out_valid}, 1);
         check("bp_data", {16'b0, out_data}, 14);
         check("bp_id", {31'b0, out_id}, 0);
         check("bp_rdy", {30'b0, req0_ready, req1_ready}, 0);
         step();
      end
      req1_valid = 0;
      out_ready = 1;
      #1;
      step();
      check("bp_rel_ov", {31'b0, out_valid}, 0);
      check("bp_rel_busy", {31'b0, busy}, 0);
      req0_valid = 1; req0_data = 16'd7;
      #1;
      wait_rdy(0, ok);
      step();
      req0_valid = 0;
      step();
      rst = 1;
      step();
      rst = 0;
      check("rst_mid_busy", {31'b0, busy}, 0);
      check("rst_mid_ov", {31'b0, out_valid}, 0);
      for (int i = 0; i < 4; i++) begin
         step();
         check("rst_mid_quiet", {31'b0, out_valid}, 0);
      end
      single(1, 16'd1, 16'd3);
      out_ready = 1;
      req0_valid = 1; req0_data = xs[0];
      #1;
      last_cyc = 0;
      for (int k = 0; k < 3; k++) begin
         wait_rdy(0, ok);
         if (k > 0) check("b2b_gap", cyc - last_cyc, 4);
         last_cyc = cyc;
         step();
         req0_data = (k < 2) ? xs[k + 1] : xs[k];
         step();
         step();
         check("b2b_ov", {31'b0, out_valid}, 1);
         check("b2b_data", {16'b0, out_data}, {16'b0, ys[k]});
         step();
      end
      req0_valid = 0;
      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
